// File: rtl/random_box_gen.sv
// rtl/random_box_gen.sv - LFSR-driven one-hot food-box position generator for the 7x5 snake array.
// Optional macro RANDOM_BOX_NO_REPEAT_EN forces every drive update to move the box.
module random_box_gen #(
  parameter int unsigned          LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED      = 16'hACE1,
  parameter logic [6:0]           RST_BOX_X  = 7'b0100000,
  parameter logic [4:0]           RST_BOX_Y  = 5'b00010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drive,
  output logic [6:0] box_x,
  output logic [4:0] box_y
);

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [6:0]            box_x_q, box_x_d;
  logic [4:0]            box_y_q, box_y_d;
  logic [2:0]            x_raw, y_raw, x_idx, y_idx;
  logic [6:0]            cand_x;
  logic [4:0]            cand_y;
  logic                  fb;

  always_comb begin
    fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = {lfsr_q[14:0], fb};

    // Compare-and-subtract modulo: one subtraction suffices for 3-bit inputs.
    x_raw = lfsr_q[2:0];
    y_raw = lfsr_q[10:8];
    x_idx = (x_raw == 3'd7) ? 3'd0 : x_raw;
    y_idx = (y_raw >= 3'd5) ? (y_raw - 3'd5) : y_raw;

    cand_x = 7'b0000001 << x_idx;
    cand_y = 5'b00001 << y_idx;
`ifdef RANDOM_BOX_NO_REPEAT_EN
    if ((cand_x == box_x_q) && (cand_y == box_y_q)) begin
      x_idx  = (x_idx == 3'd6) ? 3'd0 : (x_idx + 3'd1);
      cand_x = 7'b0000001 << x_idx;
    end
`endif

    box_x_d = box_x_q;
    box_y_d = box_y_q;
    if (drive) begin
      box_x_d = cand_x;
      box_y_d = cand_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= SEED;
      box_x_q <= RST_BOX_X;
      box_y_q <= RST_BOX_Y;
    end else begin
      lfsr_q  <= lfsr_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
    end
  end

  assign box_x = box_x_q;
  assign box_y = box_y_q;

endmodule

// File: tb/tb_random_box_gen.sv
// tb/tb_random_box_gen.sv - randomized self-checking bench for random_box_gen against an arithmetic model.
module tb_random_box_gen;

  logic       clk;
  logic       rst_n;
  logic       drive;
  logic [6:0] box_x;
  logic [4:0] box_y;

  int n_chk;
  int n_fail;

  logic [15:0] m_lfsr;
  logic [6:0]  m_bx;
  logic [4:0]  m_by;

  random_box_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .drive (drive),
    .box_x (box_x),
    .box_y (box_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic m_reset();
    m_lfsr = 16'hACE1;
    m_bx   = 7'b0100000;
    m_by   = 5'b00010;
  endtask

  // Advances the model by one edge and compares the DUT outputs after it.
  task automatic tick(input logic d, input string name);
    int xi, yi;
    logic [6:0] cx;
    logic [4:0] cy;
    drive = d;
    @(posedge clk);
    #1;
    if (d) begin
      xi = int'(m_lfsr & 16'h7) % 7;
      yi = int'((m_lfsr >> 8) & 16'h7) % 5;
      cx = 7'(1 << xi);
      cy = 5'(1 << yi);
`ifdef RANDOM_BOX_NO_REPEAT_EN
      if (cx == m_bx && cy == m_by) cx = 7'(1 << ((xi + 1) % 7));
`endif
      m_bx = cx;
      m_by = cy;
    end
    m_lfsr = m_step(m_lfsr);
    n_chk++;
    if (box_x !== m_bx || box_y !== m_by) begin
      n_fail++;
      $display("FAIL %s: got x=%b y=%b expected x=%b y=%b", name, box_x, box_y, m_bx, m_by);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (box_x !== 7'b0100000 || box_y !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_async: got x=%b y=%b expected x=0100000 y=00010", box_x, box_y);
    end
    drive = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_chk++;
    if (box_x !== 7'b0100000 || box_y !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_held: got x=%b y=%b expected x=0100000 y=00010", box_x, box_y);
    end
    drive = 1'b0;
    #2;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_first_draws();
    tick(1'b1, "first_draw_model");
    n_chk++;
    if (box_x !== 7'b0000010 || box_y !== 5'b10000) begin
      n_fail++;
      $display("FAIL first_draw: got x=%b y=%b expected x=0000010 y=10000", box_x, box_y);
    end
    tick(1'b1, "second_draw_model");
    n_chk++;
    if (box_x !== 7'b0001000 || box_y !== 5'b00010) begin
      n_fail++;
      $display("FAIL second_draw: got x=%b y=%b expected x=0001000 y=00010", box_x, box_y);
    end
  endtask

  task automatic test_hold();
    logic [6:0] sx;
    logic [4:0] sy;
    sx = box_x;
    sy = box_y;
    for (int i = 0; i < 20; i++) tick(1'b0, "hold_model");
    n_chk++;
    if (box_x !== sx || box_y !== sy) begin
      n_fail++;
      $display("FAIL hold_unchanged: got x=%b y=%b expected x=%b y=%b", box_x, box_y, sx, sy);
    end
    tick(1'b1, "draw_after_idle");
  endtask

  task automatic test_sweep();
    logic [6:0] seen_x;
    logic [4:0] seen_y;
    logic [6:0] px;
    logic [4:0] py;
    logic       d;
    int         bad_hot;
    int         bad_rep;
    seen_x  = '0;
    seen_y  = '0;
    bad_hot = 0;
    bad_rep = 0;
    for (int i = 0; i < 2000; i++) begin
      d  = 1'($urandom_range(0, 1));
      px = box_x;
      py = box_y;
      tick(d, "sweep_model");
      if (!$onehot(box_x) || !$onehot(box_y)) bad_hot++;
`ifdef RANDOM_BOX_NO_REPEAT_EN
      if (d && box_x == px && box_y == py) bad_rep++;
`endif
      seen_x |= box_x;
      seen_y |= box_y;
    end
    n_chk++;
    if (bad_hot != 0) begin
      n_fail++;
      $display("FAIL sweep_onehot: got %0d non-one-hot cycles expected 0", bad_hot);
    end
    n_chk++;
    if (seen_x !== 7'h7f || seen_y !== 5'h1f) begin
      n_fail++;
      $display("FAIL sweep_coverage: got cols=%b rows=%b expected 1111111 11111", seen_x, seen_y);
    end
`ifdef RANDOM_BOX_NO_REPEAT_EN
    n_chk++;
    if (bad_rep != 0) begin
      n_fail++;
      $display("FAIL sweep_no_repeat: got %0d unchanged draws expected 0", bad_rep);
    end
`endif
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 50; i++) tick(1'b1, "pre_reset_draws");
    drive = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (box_x !== 7'b0100000 || box_y !== 5'b00010) begin
      n_fail++;
      $display("FAIL midrun_reset: got x=%b y=%b expected x=0100000 y=00010", box_x, box_y);
    end
    #1;
    rst_n = 1'b1;
    m_reset();
    tick(1'b1, "post_reset_model");
    n_chk++;
    if (box_x !== 7'b0000010 || box_y !== 5'b10000) begin
      n_fail++;
      $display("FAIL post_reset_first_draw: got x=%b y=%b expected x=0000010 y=10000", box_x, box_y);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_first_draws();
    test_hold();
    test_sweep();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
